// File: rtl/usb_host_line_receiver.sv
// usb_host_line_receiver: NRZI decode, SYNC detect, bit unstuffing and EOP check on the host receive path
module usb_host_line_receiver #(
  parameter int MIN_SYNC_ZEROS = 5,
  parameter int MAX_SE0_BITS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] J_state,
  input  logic [1:0] K_state,
  input  logic [1:0] usb_signals_in,
  input  logic       rx_enable,
  input  logic       bit_strobe,
  output logic       serial_data_out,
  output logic       serial_data_out_val,
  output logic       rx_active,
  output logic       rx_done,
  output logic       rx_error
);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERROR} state_t;
  localparam int SW = $clog2(MAX_SE0_BITS + 2);
  localparam logic [2:0] MIN_Z = 3'(MIN_SYNC_ZEROS);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_SE0_BITS);
  state_t state;
  logic [1:0] prev_line;
  logic [2:0] zero_cnt;
  logic [2:0] ones_cnt;
  logic [2:0] bit_cnt;
  logic [SW-1:0] se0_cnt;
  logic is_j;
  logic is_k;
  logic is_se0;
  logic jk;
  logic dec;
  logic fail;
  always_comb begin
    is_j = usb_signals_in == J_state;
    is_k = usb_signals_in == K_state;
    is_se0 = usb_signals_in == 2'b00;
    jk = is_j | is_k;
    dec = usb_signals_in == prev_line;
    fail = bit_strobe && (
      (state == SYNC && (!jk || (dec && zero_cnt < MIN_Z))) ||
      (state == DATA && ((!jk && !is_se0) || (jk && dec && ones_cnt == 3'd6))) ||
      (state == EOP && (is_k || (!jk && !is_se0) || (is_j && bit_cnt != 3'd0) ||
                        (is_se0 && se0_cnt >= MAX_S))));
  end
  always_ff @(posedge clock) begin
    if (reset || !rx_enable) begin
      state <= IDLE;
      prev_line <= J_state;
      zero_cnt <= 3'd0;
      ones_cnt <= 3'd0;
      bit_cnt <= 3'd0;
      se0_cnt <= '0;
      serial_data_out <= 1'b0;
      serial_data_out_val <= 1'b0;
      rx_active <= 1'b0;
      rx_done <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      serial_data_out_val <= 1'b0;
      rx_done <= 1'b0;
      rx_error <= 1'b0;
      if (bit_strobe && jk) prev_line <= usb_signals_in;
      if (fail) begin
        state <= ERROR;
        rx_active <= 1'b0;
        rx_error <= 1'b1;
        se0_cnt <= '0;
      end else if (bit_strobe) begin
        case (state)
          IDLE: if (is_k) begin
            state <= SYNC;
            zero_cnt <= 3'd1;
          end
          SYNC: if (!dec) zero_cnt <= (zero_cnt == 3'd7) ? zero_cnt : zero_cnt + 3'd1;
          else begin
            state <= DATA;
            ones_cnt <= 3'd1;
            bit_cnt <= 3'd0;
            rx_active <= 1'b1;
          end
          DATA: if (is_se0) begin
            state <= EOP;
            se0_cnt <= SW'(1);
          end else if (ones_cnt == 3'd6) ones_cnt <= 3'd0;
          else begin
            serial_data_out <= dec;
            serial_data_out_val <= 1'b1;
            bit_cnt <= bit_cnt + 3'd1;
            ones_cnt <= dec ? ones_cnt + 3'd1 : 3'd0;
          end
          EOP: if (is_se0) se0_cnt <= se0_cnt + SW'(1);
          else begin
            state <= IDLE;
            rx_active <= 1'b0;
            rx_done <= 1'b1;
            se0_cnt <= '0;
          end
          default: if (is_se0) se0_cnt <= SW'(1);
          else if (is_j && se0_cnt != '0) begin
            state <= IDLE;
            se0_cnt <= '0;
          end else se0_cnt <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_host_line_receiver.sv
// tb_usb_host_line_receiver: table-driven packet vectors plus abort sequences for the line receiver
module tb_usb_host_line_receiver;
  localparam logic [1:0] J = 2'b10, K = 2'b01, S0 = 2'b00;
  localparam logic [4:0] Z = 5'b00000, A = 5'b00100, V1 = 5'b11100, V0 = 5'b10100;
  localparam logic [4:0] D = 5'b00010, E = 5'b00001;
  logic clock = 0;
  logic reset = 1;
  logic rx_enable = 1;
  logic bit_strobe = 0;
  logic [1:0] usb_signals_in = J;
  logic serial_data_out, serial_data_out_val, rx_active, rx_done, rx_error;
  typedef struct {
    logic [1:0] line;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[$];
  int seg_first[5], seg_last[5], seg_nv[5], seg_nd[5], seg_ne[5];
  string seg_name[5];
  int checks = 0, errors = 0, n_val = 0, n_done = 0, n_err = 0;

  usb_host_line_receiver dut (
    .clock(clock), .reset(reset), .J_state(J), .K_state(K),
    .usb_signals_in(usb_signals_in), .rx_enable(rx_enable), .bit_strobe(bit_strobe),
    .serial_data_out(serial_data_out), .serial_data_out_val(serial_data_out_val),
    .rx_active(rx_active), .rx_done(rx_done), .rx_error(rx_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (serial_data_out_val) n_val++;
    if (rx_done) n_done++;
    if (rx_error) n_err++;
    if (rx_done && rx_error) begin
      errors++;
      $display("FAIL done_with_error at %0t: rx_done and rx_error both 1, required not both", $time);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [1:0] l, input logic [4:0] e, input int n = 1);
    for (int i = 0; i < n; i++) tbl.push_back('{l, e});
  endtask

  task automatic add_sync();
    add(K, Z); add(J, Z); add(K, Z); add(J, Z); add(K, Z); add(J, Z); add(K, Z); add(K, A);
  endtask

  task automatic seg_begin(input int s, input string name, input int nv, input int nd, input int ne);
    seg_first[s] = tbl.size();
    seg_name[s] = name;
    seg_nv[s] = nv;
    seg_nd[s] = nd;
    seg_ne[s] = ne;
  endtask

  task automatic apply(input logic [1:0] l, input int gap, output logic [4:0] got);
    @(negedge clock);
    usb_signals_in = l;
    bit_strobe = 1;
    @(posedge clock);
    #1;
    got = {serial_data_out_val, serial_data_out_val & serial_data_out, rx_active, rx_done, rx_error};
    bit_strobe = 0;
    repeat (gap) @(posedge clock);
  endtask

  task automatic run_range(input int first, input int last, input int gap, input string name);
    logic [4:0] got;
    for (int i = first; i <= last; i++) begin
      apply(tbl[i].line, gap, got);
      check($sformatf("%s[%0d]", name, i - first), int'(got), int'(tbl[i].exp));
    end
  endtask

  task automatic run_seg(input int s, input int gap);
    int v0, d0, e0;
    v0 = n_val;
    d0 = n_done;
    e0 = n_err;
    run_range(seg_first[s], seg_last[s], gap, seg_name[s]);
    repeat (2) @(posedge clock);
    check({seg_name[s], "_vals"}, n_val - v0, seg_nv[s]);
    check({seg_name[s], "_dones"}, n_done - d0, seg_nd[s]);
    check({seg_name[s], "_errors"}, n_err - e0, seg_ne[s]);
  endtask

  task automatic abort_test(input bit use_reset);
    int d0, e0;
    string nm;
    nm = use_reset ? "reset_abort" : "enable_abort";
    run_range(seg_first[0], seg_first[0] + 10, 3, {nm, "_pre"});
    d0 = n_done;
    e0 = n_err;
    @(negedge clock);
    usb_signals_in = K;
    bit_strobe = 1;
    if (use_reset) reset = 1;
    else rx_enable = 0;
    @(posedge clock);
    #1;
    check({nm, "_outputs"},
          int'({serial_data_out_val, serial_data_out, rx_active, rx_done, rx_error}), 0);
    bit_strobe = 0;
    reset = 0;
    rx_enable = 1;
    repeat (3) @(posedge clock);
    check({nm, "_dones"}, n_done - d0, 0);
    check({nm, "_errors"}, n_err - e0, 0);
  endtask

  initial begin
    seg_begin(0, "clean", 8, 1, 0);
    add_sync();
    add(K, V1); add(J, V0); add(J, V1); add(K, V0); add(J, V0); add(J, V1); add(K, V0); add(K, V1);
    add(S0, A, 2); add(J, D);
    seg_last[0] = tbl.size() - 1;
    seg_begin(1, "stuff", 8, 1, 0);
    add_sync();
    add(K, V1, 5); add(J, A); add(J, V1, 3); add(S0, A, 2); add(J, D);
    seg_last[1] = tbl.size() - 1;
    seg_begin(2, "stuff_err", 5, 0, 1);
    add_sync();
    add(K, V1, 5); add(K, E); add(K, Z); add(S0, Z); add(J, Z);
    seg_last[2] = tbl.size() - 1;
    seg_begin(3, "misaligned", 5, 0, 1);
    add_sync();
    add(K, V1); add(J, V0); add(K, V0); add(J, V0); add(J, V1);
    add(S0, A, 2); add(J, E); add(S0, Z); add(J, Z);
    seg_last[3] = tbl.size() - 1;
    seg_begin(4, "short_sync", 0, 0, 1);
    add(K, Z); add(J, Z); add(K, Z); add(K, E); add(S0, Z); add(J, Z);
    seg_last[4] = tbl.size() - 1;

    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs",
          int'({serial_data_out_val, serial_data_out, rx_active, rx_done, rx_error}), 0);
    @(negedge clock);
    reset = 0;
    for (int s = 0; s < 5; s++) run_seg(s, 3);
    abort_test(0);
    run_seg(0, 3);
    abort_test(1);
    run_seg(0, 3);
    run_seg(1, 0);
    run_seg(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
